// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_RD_WAIT
  } arb_state_t;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned LAT_W      = $clog2(RD_LAT_MAX);
  localparam int unsigned STARVE_W   = 8;

  // Latency counter start value: counts RD_LAT-1 down to 0 while a read is in flight.
  function automatic logic [LAT_W-1:0] lat_preload(input int unsigned rd_lat);
    return LAT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the DMA port has been refused.
module arb_starve_ctr
  import arm_mem_pkg::*;
#(
  parameter int unsigned LIM = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  logic [STARVE_W-1:0] r_cnt;
  logic [STARVE_W-1:0] w_lim;

  assign w_lim = STARVE_W'(LIM);

  // Count refused cycles; clear wins over increment, hold once the limit is reached.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != w_lim)) begin
      r_cnt <= r_cnt + STARVE_W'(1);
    end
  end

  assign o_at_limit = (r_cnt == w_lim);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a DMA port.
// CPU has fixed priority; a starvation counter forces DMA through after STARVE_LIM refusals.
module dmem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  owner_t           r_owner;
  owner_t           w_owner_nxt;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [LAT_W-1:0] w_lat_nxt;

  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic w_starve;
  logic w_starve_inc;
  logic w_starve_clr;
  logic w_dma_win;
  logic w_cpu_win;
  logic w_cpu_wr_issue;
  logic w_ret;
  logic w_cpu_ret;
  logic w_dma_ret;

  // Issue is suppressed while reset is held so no strobe escapes during reset.
  assign w_dma_win = reset & dma_req & (w_starve | ~cpu_req);
  assign w_cpu_win = reset & cpu_req;

  assign w_starve_inc = dma_req & ~dma_gnt;
  assign w_starve_clr = ~dma_req | dma_gnt;

  arb_starve_ctr #(
    .LIM(STARVE_LIM)
  ) u_starve_ctr (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_inc      (w_starve_inc),
    .i_clr      (w_starve_clr),
    .o_at_limit (w_starve)
  );

  // Arbitration, memory strobe muxing and next-state selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_lat_nxt      = r_lat_cnt;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    dma_gnt        = 1'b0;
    w_cpu_wr_issue = 1'b0;
    w_ret          = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (r_state == ARB_IDLE && w_dma_win) begin
          mem_en    = 1'b1;
          mem_we    = dma_we;
          mem_addr  = dma_addr;
          mem_wdata = dma_wdata;
          dma_gnt   = 1'b1;
          if (!dma_we) begin
            w_state_nxt = ARB_RD_WAIT;
            w_owner_nxt = OWN_DMA;
            w_lat_nxt   = lat_preload(RD_LAT);
          end
        end else if (w_cpu_win) begin
          mem_en         = 1'b1;
          mem_we         = cpu_we;
          mem_addr       = cpu_addr;
          mem_wdata      = cpu_wdata;
          w_cpu_wr_issue = cpu_we;
          if (!cpu_we) begin
            w_state_nxt = ARB_RD_WAIT;
            w_owner_nxt = OWN_CPU;
            w_lat_nxt   = lat_preload(RD_LAT);
          end
        end
      end
      ARB_RD_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_ret       = 1'b1;
          w_state_nxt = ARB_IDLE;
          w_owner_nxt = OWN_NONE;
        end else begin
          w_lat_nxt = r_lat_cnt - LAT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  // FSM state, read owner and latency counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_NONE;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_lat_cnt <= w_lat_nxt;
    end
  end

  assign w_cpu_ret = w_ret & (r_owner == OWN_CPU);
  assign w_dma_ret = w_ret & (r_owner == OWN_DMA);

  // Capture returning read data into the owning port's holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_cpu_ret) r_cpu_rdata <= mem_rdata;
      if (w_dma_ret) r_dma_rdata <= mem_rdata;
    end
  end

  // In the return cycle the data is forwarded straight from memory so the
  // consumer sees it in the same cycle the stall drops / rvalid pulses;
  // afterwards the registered copy holds it.
  assign cpu_rdata  = w_cpu_ret ? mem_rdata : r_cpu_rdata;
  assign dma_rdata  = w_dma_ret ? mem_rdata : r_dma_rdata;
  assign dma_rvalid = w_dma_ret;
  assign cpu_stall  = reset & cpu_req & ~(w_cpu_wr_issue | w_cpu_ret);

endmodule
